// File: rtl/ne16_ctrl_nested_counter_pkg.sv
// Shared types and defaults for the NE16 controller nested loop counter.
// Imported by the interface, the per-level sub-module and the top.
package ne16_ctrl_nested_counter_pkg;

  localparam int unsigned NE16_NESTED_CNT_LEVELS = 3;
  localparam int unsigned NE16_NESTED_CNT_BITS   = 16;

  typedef enum logic {
    NC_IDLE = 1'b0,
    NC_RUN  = 1'b1
  } ne16_nested_cnt_state_t;

endpackage

// File: rtl/ne16_ctrl_nested_counter_if.sv
// Control/status bundle between the ctrl FSM (master) and the nested counter (slave).
interface ne16_ctrl_nested_counter_if
  import ne16_ctrl_nested_counter_pkg::*;
#(
  parameter int unsigned NB_LEVELS = NE16_NESTED_CNT_LEVELS,
  parameter int unsigned BITS      = NE16_NESTED_CNT_BITS
);

  logic                           test_mode_i;
  logic                           clear_i;
  logic                           start_i;
  logic                           enable_i;
  logic [NB_LEVELS-1:0][BITS-1:0] limits_i;
  logic [NB_LEVELS-1:0][BITS-1:0] count_o;
  logic [NB_LEVELS-1:0]           last_o;
  logic [NB_LEVELS-1:0]           wrap_o;
  logic                           busy_o;
  logic                           done_o;

  modport master (
    output test_mode_i, clear_i, start_i, enable_i, limits_i,
    input  count_o, last_o, wrap_o, busy_o, done_o
  );

  modport slave (
    input  test_mode_i, clear_i, start_i, enable_i, limits_i,
    output count_o, last_o, wrap_o, busy_o, done_o
  );

endinterface

// File: rtl/ne16_ctrl_loop_level.sv
// One level of the nested loop: holds the index and the registered wrap pulse.
module ne16_ctrl_loop_level
  import ne16_ctrl_nested_counter_pkg::*;
#(
  parameter int unsigned BITS = NE16_NESTED_CNT_BITS
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [BITS-1:0] lim_m1_i,
  output logic [BITS-1:0] cnt_o,
  output logic            last_o,
  output logic            wrap_o
);

  logic [BITS-1:0] cnt_q;
  logic            wrap_q;

  // lim_m1_i comes from a register in the top, so last is flop-to-flop only
  assign last_o = (cnt_q == lim_m1_i);
  assign cnt_o  = cnt_q;
  assign wrap_o = wrap_q;

  // Index update: wrap to zero on the final iteration, never past lim_m1_i
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= {BITS{1'b0}};
      wrap_q <= 1'b0;
    end else if (clear_i || load_i) begin
      cnt_q  <= {BITS{1'b0}};
      wrap_q <= 1'b0;
    end else if (step_i) begin
      if (last_o) begin
        cnt_q  <= {BITS{1'b0}};
        wrap_q <= 1'b1;
      end else begin
        cnt_q  <= cnt_q + BITS'(1'b1);
        wrap_q <= 1'b0;
      end
    end else begin
      cnt_q  <= cnt_q;
      wrap_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ne16_ctrl_nested_counter.sv
// N-level nested loop counter: IDLE/RUN FSM, latched limits, carry chain and done pulse.
// Level 0 is innermost; a level steps only when every inner level is on its last iteration.
module ne16_ctrl_nested_counter
  import ne16_ctrl_nested_counter_pkg::*;
#(
  parameter int unsigned NB_LEVELS = NE16_NESTED_CNT_LEVELS,
  parameter int unsigned BITS      = NE16_NESTED_CNT_BITS
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  ne16_ctrl_nested_counter_if.slave   bus
);

  ne16_nested_cnt_state_t         state_q;
  logic [NB_LEVELS-1:0][BITS-1:0] lim_m1_q;
  logic [NB_LEVELS-1:0][BITS-1:0] cnt_s;
  logic [NB_LEVELS-1:0]           last_s;
  logic [NB_LEVELS-1:0]           wrap_s;
  logic [NB_LEVELS-1:0]           step_s;
  logic                           done_q;
  logic                           run_s;
  logic                           load_s;
  logic                           final_s;
  logic                           unused_test_mode_s;

  // A zero limit behaves as a single iteration
  function automatic logic [BITS-1:0] lim_m1_f(input logic [BITS-1:0] lim);
    logic [BITS-1:0] res;
    if (lim == {BITS{1'b0}}) begin
      res = {BITS{1'b0}};
    end else begin
      res = lim - BITS'(1'b1);
    end
    return res;
  endfunction

  assign unused_test_mode_s = bus.test_mode_i;
  assign run_s   = (state_q == NC_RUN);
  assign load_s  = (state_q == NC_IDLE) && bus.start_i;
  assign final_s = run_s && bus.enable_i && (&last_s);

  // Carry chain: each level steps when all inner levels are on their last iteration
  always_comb begin
    step_s    = {NB_LEVELS{1'b0}};
    step_s[0] = run_s && bus.enable_i;
    for (int k = 1; k < NB_LEVELS; k++) begin
      step_s[k] = step_s[k-1] && last_s[k-1];
    end
  end

  // Control FSM with limit latch and registered done pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= NC_IDLE;
      lim_m1_q <= {(NB_LEVELS*BITS){1'b0}};
      done_q   <= 1'b0;
    end else if (bus.clear_i) begin
      state_q  <= NC_IDLE;
      lim_m1_q <= {(NB_LEVELS*BITS){1'b0}};
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        NC_IDLE: begin
          done_q <= 1'b0;
          if (bus.start_i) begin
            state_q <= NC_RUN;
            for (int k = 0; k < NB_LEVELS; k++) begin
              lim_m1_q[k] <= lim_m1_f(bus.limits_i[k]);
            end
          end else begin
            state_q <= NC_IDLE;
          end
        end
        NC_RUN: begin
          if (final_s) begin
            state_q <= NC_IDLE;
            done_q  <= 1'b1;
          end else begin
            state_q <= NC_RUN;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= NC_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NB_LEVELS; k++) begin : g_level
    ne16_ctrl_loop_level #(
      .BITS(BITS)
    ) u_level (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (bus.clear_i),
      .load_i   (load_s),
      .step_i   (step_s[k]),
      .lim_m1_i (lim_m1_q[k]),
      .cnt_o    (cnt_s[k]),
      .last_o   (last_s[k]),
      .wrap_o   (wrap_s[k])
    );
  end

  assign bus.count_o = cnt_s;
  assign bus.last_o  = last_s & {NB_LEVELS{run_s}};
  assign bus.wrap_o  = wrap_s;
  assign bus.busy_o  = run_s;
  assign bus.done_o  = done_q;

endmodule

// File: tb/tb_ne16_ctrl_nested_counter.sv
// Bench for the nested loop counter: directed scenarios plus randomized runs, checked
// against a mixed-radix model (step number n -> per-level digits).
module tb_ne16_ctrl_nested_counter;

  localparam int NL = 3;
  localparam int BW = 4;

  typedef logic [NL-1:0][BW-1:0] lim_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ne16_ctrl_nested_counter_if #(.NB_LEVELS(NL), .BITS(BW)) bus_if ();

  ne16_ctrl_nested_counter #(.NB_LEVELS(NL), .BITS(BW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_if)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: running flag, effective radices, linear step number
  bit          m_busy;
  int          m_n;
  int          m_l[NL];
  bit [NL-1:0] m_wrap;
  bit          m_done;

  function automatic int prod_below(int k);
    int p = 1;
    for (int j = 0; j < k; j++) p = p * m_l[j];
    return p;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_n = 0; m_wrap = '0; m_done = 1'b0;
    for (int k = 0; k < NL; k++) m_l[k] = 1;
  endtask

  task automatic model_edge(bit clr, bit st, bit en, lim_t lim);
    int total;
    if (clr) begin
      model_reset();
    end else if (!m_busy) begin
      m_wrap = '0; m_done = 1'b0;
      if (st) begin
        m_busy = 1'b1; m_n = 0;
        for (int k = 0; k < NL; k++) m_l[k] = (lim[k] == 0) ? 1 : int'(lim[k]);
      end
    end else if (en) begin
      total = prod_below(NL);
      for (int k = 0; k < NL; k++) m_wrap[k] = ((m_n + 1) % prod_below(k + 1)) == 0;
      if (m_n + 1 == total) begin
        m_done = 1'b1; m_busy = 1'b0; m_n = 0;
      end else begin
        m_done = 1'b0; m_n = m_n + 1;
      end
    end else begin
      m_wrap = '0; m_done = 1'b0;
    end
  endtask

  task automatic check_all(string tag);
    lim_t        ec;
    logic [NL-1:0] el;
    int          d;
    for (int k = 0; k < NL; k++) begin
      d     = (m_n / prod_below(k)) % m_l[k];
      ec[k] = BW'(d);
      el[k] = m_busy && (d == m_l[k] - 1);
    end
    checks++;
    assert (bus_if.count_o === ec) else begin
      errors++; $error("FAIL %s count observed %h expected %h", tag, bus_if.count_o, ec);
    end
    checks++;
    assert (bus_if.last_o === el) else begin
      errors++; $error("FAIL %s last observed %b expected %b", tag, bus_if.last_o, el);
    end
    checks++;
    assert (bus_if.wrap_o === m_wrap) else begin
      errors++; $error("FAIL %s wrap observed %b expected %b", tag, bus_if.wrap_o, m_wrap);
    end
    checks++;
    assert (bus_if.busy_o === m_busy) else begin
      errors++; $error("FAIL %s busy observed %b expected %b", tag, bus_if.busy_o, m_busy);
    end
    checks++;
    assert (bus_if.done_o === m_done) else begin
      errors++; $error("FAIL %s done observed %b expected %b", tag, bus_if.done_o, m_done);
    end
  endtask

  // One clock: drive, clock edge, update model, sample 1 time unit later
  task automatic step(bit clr, bit st, bit en, lim_t lim, string tag);
    bus_if.clear_i  = clr;
    bus_if.start_i  = st;
    bus_if.enable_i = en;
    bus_if.limits_i = lim;
    @(posedge clk);
    model_edge(clr, st, en, lim);
    #1;
    check_all(tag);
  endtask

  initial begin
    lim_t rl;
    lim_t zl;
    int   guard;
    zl = '0;
    bus_if.test_mode_i = 1'b0;
    bus_if.clear_i     = 1'b0;
    bus_if.start_i     = 1'b0;
    bus_if.enable_i    = 1'b0;
    bus_if.limits_i    = '0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // Enables in IDLE do nothing; enable in the start cycle is ignored
    step(1'b0, 1'b0, 1'b1, zl, "idle_en");
    step(1'b0, 1'b0, 1'b1, zl, "idle_en");

    // (L2,L1,L0) = (1,2,3): six back-to-back steps
    step(1'b0, 1'b1, 1'b1, {4'd1, 4'd2, 4'd3}, "t1_start");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, zl, "t1_run");

    // Restart in the done cycle; limits {0,1,4}
    step(1'b0, 1'b1, 1'b0, {4'd0, 4'd1, 4'd4}, "t2_start");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, zl, "t2_run");
    step(1'b0, 1'b0, 1'b0, zl, "t2_after");

    // {2,2,2} with gaps: no pulses after an idle cycle
    step(1'b0, 1'b1, 1'b0, {4'd2, 4'd2, 4'd2}, "t3_start");
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'(i % 2 == 0), zl, "t3_run");
    step(1'b0, 1'b0, 1'b0, zl, "t3_after");

    // start in RUN ignored, then clear beats enable
    step(1'b0, 1'b1, 1'b0, {4'd3, 4'd3, 4'd3}, "t4_start");
    step(1'b0, 1'b0, 1'b1, zl, "t4_run");
    step(1'b0, 1'b1, 1'b1, {4'd1, 4'd1, 4'd1}, "t4_restart_ign");
    step(1'b0, 1'b0, 1'b1, zl, "t4_run");
    step(1'b1, 1'b0, 1'b1, zl, "t4_clear");
    step(1'b0, 1'b0, 1'b1, zl, "t4_after");

    // Max limit on level 0: reaches 14, wraps, done
    step(1'b0, 1'b1, 1'b0, {4'd1, 4'd1, 4'd15}, "t5_start");
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b1, zl, "t5_run");
    step(1'b0, 1'b0, 1'b1, zl, "t5_idle_en");

    // Asynchronous reset mid-run at count 1, then restart
    step(1'b0, 1'b1, 1'b0, {4'd3, 4'd3, 4'd3}, "t6_start");
    step(1'b0, 1'b0, 1'b1, zl, "t6_run");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6_async_rst");
    #3;
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0, {4'd2, 4'd1, 4'd2}, "t6_restart");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, zl, "t6_run2");

    // Randomized runs with random enables, stray starts, rare clears
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < NL; k++) rl[k] = BW'($urandom_range(0, 5));
      step(1'b0, 1'b1, 1'($urandom_range(0, 1)), rl, "rnd_start");
      guard = 0;
      while (m_busy && guard < 1500) begin
        for (int k = 0; k < NL; k++) rl[k] = BW'($urandom_range(0, 15));
        step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) != 0), rl, "rnd_run");
        guard++;
      end
      checks++;
      assert (bus_if.busy_o === 1'b0) else begin
        errors++; $error("FAIL rnd_end busy observed %b expected 0", bus_if.busy_o);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
